// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_HI_MAX = 4'd5;
    localparam bcd_t MIN_HI_MAX = 4'd5;
    localparam bcd_t LO_MAX     = 4'd9;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One down-counting BCD digit: wraps 0 -> max_val on decrement and flags a borrow.
module bcd_down_digit
    import countdown_timer_pkg::*;
(
    input  logic clk_cin,
    input  logic rst,
    input  bcd_t max_val,
    input  logic load,
    input  bcd_t load_val,
    input  logic dec,
    output bcd_t digit,
    output logic borrow
);

    assign borrow = dec && (digit == '0);

    always_ff @(posedge clk_cin or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec) begin
            digit <= (digit == '0) ? max_val : digit - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with pause and timed alarm.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload presets at timeout instead of stopping.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned ALARM_CYCLES = 4
) (
    input  logic       clk_cin,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] preset_sec_lo,
    input  logic [3:0] preset_sec_hi,
    input  logic [3:0] preset_min_lo,
    input  logic [3:0] preset_min_hi,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       zero,
    output logic       alarm
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_CYCLES - 1);

    state_t     state, state_n;
    logic       alarm_n;
    logic [3:0] alarm_cnt, alarm_cnt_n;
    logic       dig_load, dig_dec;
    logic       one_left;

    bcd_t p_sec_lo, p_sec_hi, p_min_lo, p_min_hi;
    logic borrow_sl, borrow_sh, borrow_ml;
    logic unused_min_hi_borrow;

    assign p_sec_lo = clamp_digit(preset_sec_lo, LO_MAX);
    assign p_sec_hi = clamp_digit(preset_sec_hi, SEC_HI_MAX);
    assign p_min_lo = clamp_digit(preset_min_lo, LO_MAX);
    assign p_min_hi = clamp_digit(preset_min_hi, MIN_HI_MAX);

    assign zero     = (sec_lo == '0) && (sec_hi == '0) && (min_lo == '0) && (min_hi == '0);
    assign one_left = (sec_lo == 4'd1) && (sec_hi == '0) && (min_lo == '0) && (min_hi == '0);
    assign running  = (state == RUN);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic preset_zero;
    assign preset_zero = (p_sec_lo == '0) && (p_sec_hi == '0) && (p_min_lo == '0) && (p_min_hi == '0);
`endif

    bcd_down_digit u_sec_lo (
        .clk_cin (clk_cin), .rst (rst), .max_val (LO_MAX), .load (dig_load),
        .load_val (p_sec_lo), .dec (dig_dec), .digit (sec_lo), .borrow (borrow_sl)
    );
    bcd_down_digit u_sec_hi (
        .clk_cin (clk_cin), .rst (rst), .max_val (SEC_HI_MAX), .load (dig_load),
        .load_val (p_sec_hi), .dec (borrow_sl), .digit (sec_hi), .borrow (borrow_sh)
    );
    bcd_down_digit u_min_lo (
        .clk_cin (clk_cin), .rst (rst), .max_val (LO_MAX), .load (dig_load),
        .load_val (p_min_lo), .dec (borrow_sh), .digit (min_lo), .borrow (borrow_ml)
    );
    bcd_down_digit u_min_hi (
        .clk_cin (clk_cin), .rst (rst), .max_val (MIN_HI_MAX), .load (dig_load),
        .load_val (p_min_hi), .dec (borrow_ml), .digit (min_hi), .borrow (unused_min_hi_borrow)
    );

    always_ff @(posedge clk_cin or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state     <= state_n;
            alarm     <= alarm_n;
            alarm_cnt <= alarm_cnt_n;
        end
    end

    // Alarm timeout runs independently of state so it also expires while auto-reload keeps RUN.
    always_comb begin
        state_n     = state;
        alarm_n     = alarm;
        alarm_cnt_n = alarm_cnt;
        dig_load    = 1'b0;
        dig_dec     = 1'b0;

        if (alarm) begin
            if (alarm_cnt == '0) alarm_n = 1'b0;
            else                 alarm_cnt_n = alarm_cnt - 4'd1;
        end

        if (load) begin
            state_n     = IDLE;
            alarm_n     = 1'b0;
            alarm_cnt_n = '0;
            dig_load    = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!pause && start && !zero) state_n = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else if (zero) begin
                        state_n = IDLE;
                    end else if (one_left) begin
                        alarm_n     = 1'b1;
                        alarm_cnt_n = ALARM_LAST;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (preset_zero) begin
                            dig_dec = 1'b1;
                            state_n = IDLE;
                        end else begin
                            dig_load = 1'b1;
                        end
`else
                        dig_dec = 1'b1;
                        state_n = DONE;
`endif
                    end else begin
                        dig_dec = 1'b1;
                    end
                end
                PAUSE: begin
                    if (!pause && start) state_n = RUN;
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (default ALARM_CYCLES=4).
module tb_countdown_timer;

    logic       clk_cin = 1'b0;
    logic       rst, load, start, pause;
    logic [3:0] p_sl, p_sh, p_ml, p_mh;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic       running, zero, alarm;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.ALARM_CYCLES(4)) dut (
        .clk_cin       (clk_cin),
        .rst           (rst),
        .load          (load),
        .start         (start),
        .pause         (pause),
        .preset_sec_lo (p_sl),
        .preset_sec_hi (p_sh),
        .preset_min_lo (p_ml),
        .preset_min_hi (p_mh),
        .sec_lo        (sec_lo),
        .sec_hi        (sec_hi),
        .min_lo        (min_lo),
        .min_hi        (min_hi),
        .running       (running),
        .zero          (zero),
        .alarm         (alarm)
    );

    always #5 clk_cin = ~clk_cin;

    function automatic logic [15:0] cnt();
        return {min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    function automatic logic [2:0] flg();
        return {running, alarm, zero};
    endfunction

    task automatic tick();
        @(posedge clk_cin);
        #1;
    endtask

    task automatic do_load(input logic [15:0] p);
        {p_mh, p_ml, p_sh, p_sl} = p;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        {p_mh, p_ml, p_sh, p_sl} = 16'h0000;
        #3;
        checks++; if (cnt() !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h want=%h", cnt(), 16'h0000); end
        checks++; if (flg() !== 3'b001) begin errors++; $display("FAIL reset_flags got=%b want=%b", flg(), 3'b001); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (flg() !== 3'b001) begin errors++; $display("FAIL reset_release got=%b want=%b", flg(), 3'b001); end
    endtask

    task automatic test_countdown_done();
        do_load(16'h0003);
        checks++; if ({cnt(), flg()} !== {16'h0003, 3'b000}) begin errors++; $display("FAIL done_load got=%h/%b want=0003/000", cnt(), flg()); end
        do_start();
        checks++; if ({cnt(), flg()} !== {16'h0003, 3'b100}) begin errors++; $display("FAIL done_start got=%h/%b want=0003/100", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0002, 3'b100}) begin errors++; $display("FAIL done_t1 got=%h/%b want=0002/100", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0001, 3'b100}) begin errors++; $display("FAIL done_t2 got=%h/%b want=0001/100", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b011}) begin errors++; $display("FAIL done_t3 got=%h/%b want=0000/011", cnt(), flg()); end
        start = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if ({cnt(), flg()} !== {16'h0000, 3'b011}) begin errors++; $display("FAIL done_alarm%0d got=%h/%b want=0000/011", i, cnt(), flg()); end
        end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL done_alarm_off got=%h/%b want=0000/001", cnt(), flg()); end
        tick();
        start = 1'b0;
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL done_hold got=%h/%b want=0000/001", cnt(), flg()); end
        do_load(16'h0003);
        do_start();
        checks++; if ({cnt(), flg()} !== {16'h0003, 3'b100}) begin errors++; $display("FAIL done_reload got=%h/%b want=0003/100", cnt(), flg()); end
    endtask

    task automatic test_borrow();
        do_load(16'h1000);
        do_start();
        tick();
        checks++; if (cnt() !== 16'h0959) begin errors++; $display("FAIL borrow_1 got=%h want=%h", cnt(), 16'h0959); end
        repeat (60) tick();
        checks++; if (cnt() !== 16'h0859) begin errors++; $display("FAIL borrow_60 got=%h want=%h", cnt(), 16'h0859); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL borrow_running got=%b want=1", running); end
    endtask

    task automatic test_pause();
        do_load(16'h0005);
        do_start();
        tick(); tick();
        checks++; if (cnt() !== 16'h0003) begin errors++; $display("FAIL pause_pre got=%h want=%h", cnt(), 16'h0003); end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({cnt(), running} !== {16'h0003, 1'b0}) begin errors++; $display("FAIL pause_hold%0d got=%h/%b want=0003/0", i, cnt(), running); end
        end
        pause = 1'b0;
        do_start();
        checks++; if ({cnt(), running} !== {16'h0003, 1'b1}) begin errors++; $display("FAIL pause_resume got=%h/%b want=0003/1", cnt(), running); end
        tick();
        checks++; if (cnt() !== 16'h0002) begin errors++; $display("FAIL pause_next got=%h want=%h", cnt(), 16'h0002); end
    endtask

    task automatic test_clamp_priority();
        do_load(16'h007C);
        checks++; if (cnt() !== 16'h0059) begin errors++; $display("FAIL clamp_sec got=%h want=%h", cnt(), 16'h0059); end
        do_load(16'hCF00);
        checks++; if (cnt() !== 16'h5900) begin errors++; $display("FAIL clamp_min got=%h want=%h", cnt(), 16'h5900); end
        {p_mh, p_ml, p_sh, p_sl} = 16'h007C;
        load = 1'b1; start = 1'b1; pause = 1'b1;
        tick();
        load = 1'b0; start = 1'b0; pause = 1'b0;
        checks++; if ({cnt(), flg()} !== {16'h0059, 3'b000}) begin errors++; $display("FAIL prio_all got=%h/%b want=0059/000", cnt(), flg()); end
        start = 1'b1; pause = 1'b1;
        tick();
        start = 1'b0; pause = 1'b0;
        checks++; if ({cnt(), running} !== {16'h0059, 1'b0}) begin errors++; $display("FAIL prio_pause got=%h/%b want=0059/0", cnt(), running); end
        do_load(16'h0000);
        do_start();
        checks++; if (flg() !== 3'b001) begin errors++; $display("FAIL idle_zero_start got=%b want=%b", flg(), 3'b001); end
    endtask

    task automatic test_async_reset();
        do_load(16'h0130);
        do_start();
        tick(); tick(); tick();
        checks++; if (cnt() !== 16'h0127) begin errors++; $display("FAIL rst_run_pre got=%h want=%h", cnt(), 16'h0127); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL rst_run got=%h/%b want=0000/001", cnt(), flg()); end
        tick();
        rst = 1'b0;
        do_load(16'h0130);
        do_start();
        tick();
        checks++; if (cnt() !== 16'h0129) begin errors++; $display("FAIL rst_run_restart got=%h want=%h", cnt(), 16'h0129); end
        do_load(16'h0001);
        do_start();
        tick();
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL rst_alarm_pre got=%b want=1", alarm); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL rst_alarm got=%h/%b want=0000/001", cnt(), flg()); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b001}) begin errors++; $display("FAIL rst_alarm_after got=%h/%b want=0000/001", cnt(), flg()); end
    endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        do_load(16'h0002);
        do_start();
        checks++; if ({cnt(), flg()} !== {16'h0002, 3'b100}) begin errors++; $display("FAIL ar_start got=%h/%b want=0002/100", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0001, 3'b100}) begin errors++; $display("FAIL ar_t1 got=%h/%b want=0001/100", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0002, 3'b110}) begin errors++; $display("FAIL ar_reload got=%h/%b want=0002/110", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0001, 3'b110}) begin errors++; $display("FAIL ar_t3 got=%h/%b want=0001/110", cnt(), flg()); end
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0002, 3'b110}) begin errors++; $display("FAIL ar_reload2 got=%h/%b want=0002/110", cnt(), flg()); end
        {p_mh, p_ml, p_sh, p_sl} = 16'h0000;
        tick();
        tick();
        checks++; if ({cnt(), flg()} !== {16'h0000, 3'b011}) begin errors++; $display("FAIL ar_zero_stop got=%h/%b want=0000/011", cnt(), flg()); end
        tick();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL ar_zero_idle got=%b want=0", running); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_countdown_done();
`endif
        test_borrow();
        test_pause();
        test_clamp_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter ALARM_CYCLES, default 4: number of clk_cin cycles alarm stays high after the count reaches zero (range 1..15).
REQ-002 SHALL have port clk_cin  input  1  count clock (one tick per second); reset rst, asynchronous, active-high; clock clk_cin.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port load  input  1  synchronous load of the preset digits; highest priority.
REQ-005 SHALL have port start  input  1  start or resume the countdown.
REQ-006 SHALL have port pause  input  1  hold the count while running.
REQ-007 SHALL have ports preset_sec_lo, preset_sec_hi, preset_min_lo, preset_min_hi  input  4 each  BCD preset digits.
REQ-008 SHALL have ports sec_lo, sec_hi, min_lo, min_hi  output  4 each  current BCD count (MM:SS).
REQ-009 SHALL have port running  output  1  high while state is RUN.
REQ-010 SHALL have port zero  output  1  combinational: all four digits equal 0.
REQ-011 SHALL have port alarm  output  1  timeout indication.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE, DONE; all updates on posedge clk_cin.
REQ-013 SHALL give priority per edge: load > pause > start.
REQ-014 load in any state SHALL write clamped presets to the digits, go to IDLE, and clear alarm and alarm counter.
REQ-015 Clamping SHALL be: lo digits >9 become 9; hi digits >5 become 5.
REQ-016 IDLE + start + zero low SHALL go to RUN; no decrement on that edge.
REQ-017 IDLE + start + zero high SHALL stay in IDLE.
REQ-018 In RUN, each edge without load or pause SHALL decrement the count by one second.
REQ-019 Decrement SHALL borrow as: sec_lo 0->9 borrows from sec_hi; sec_hi 0->5 borrows from min_lo; min_lo 0->9 borrows from min_hi.
REQ-020 The edge that changes 00:01 to 00:00 SHALL enter DONE and set alarm high.
REQ-021 RUN + pause SHALL go to PAUSE with the count held; PAUSE + start with pause low SHALL return to RUN.
REQ-022 In DONE, alarm SHALL stay high for exactly ALARM_CYCLES edges, then go low; DONE SHALL persist until load; start SHALL be ignored.
REQ-023 The count SHALL never underflow below 00:00 (no wrap from 00:00 to 59:59).

Reset
REQ-024 rst SHALL force IDLE, all digits 0, alarm 0, running 0, alarm counter 0 (zero therefore 1), immediately and regardless of clock.
REQ-025 rst asserted mid-RUN or mid-alarm SHALL abort with no residual borrow or alarm.

Configuration
REQ-026 Macro COUNTDOWN_AUTO_RELOAD_EN defined: the 00:01->00:00 edge SHALL instead reload the clamped presets, stay in RUN, and pulse alarm for ALARM_CYCLES edges; DONE SHALL be unreachable.
REQ-027 With auto-reload, an all-zero preset SHALL stop in IDLE, never looping.
REQ-028 Macro undefined: behaviour per REQ-020/REQ-022.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/RUN/PAUSE/DONE), constants SEC_HI_MAX=5, MIN_HI_MAX=5, LO_MAX=9, and the BCD digit typedef (4 bits).
REQ-030 SHALL instantiate sub-module bcd_down_digit four times: one down-counting BCD digit with max-value input, load, decrement enable, and borrow-out (high when digit is 0 and decrementing).

Verification
REQ-031 SHALL cover: preset 00:03, load, start -> digits 00:02, 00:01, 00:00 on the three edges after the start edge; alarm high 4 edges; state DONE.
REQ-032 SHALL cover: preset 10:00, run one edge -> 09:59; then run 60 edges -> 08:59.
REQ-033 SHALL cover: preset 00:05, start, 2 edges, pause 3 edges -> held at 00:03; start -> 00:02 next edge.
REQ-034 SHALL cover: preset_sec_hi=7, preset_sec_lo=12, load -> sec_hi=5, sec_lo=9; load+start+pause same edge -> IDLE, count 00:59.
REQ-035 SHALL cover: rst asserted between edges during alarm -> alarm 0, digits 00:00, running 0 without a clock edge.
REQ-036 SHALL cover: with COUNTDOWN_AUTO_RELOAD_EN and preset 00:02 -> 00:01, 00:02 (alarm high), 00:01, ... running stays 1.
